// File: rtl/pe_pkg.sv
// Shared definitions for the request-pending / priority-offer path.
// Contents:
//   N_REQ, IDX_W  - number of request lines and index width
//   state_e       - offer FSM states
//   highest_set   - index of the top set bit (0 for an all-zero vector;
//                   callers gate the result with |vec)
//   one_hot       - index to one-hot vector
package pe_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic logic [IDX_W-1:0] highest_set(input logic [N_REQ-1:0] vec);
    highest_set = '0;
    // Scanning upward means the last hit is the highest-priority line.
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) highest_set = IDX_W'(i);
    end
  endfunction

  function automatic logic [N_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
    one_hot      = '0;
    one_hot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/irq_pending_arbiter_if.sv
// Offer handshake between the arbiter and its downstream consumer.
// Signals:
//   idx   - offered line index (driven by master)
//   valid - idx is valid (driven by master)
//   ready - consumer accepts (driven by slave); transfer when valid && ready
interface irq_pending_arbiter_if;
  import pe_pkg::*;

  logic [IDX_W-1:0] idx;
  logic             valid;
  logic             ready;

  modport master (output idx, output valid, input ready);
  modport slave  (input idx, input valid, output ready);

endinterface

// File: rtl/req_capture.sv
// Request capture: turns request lines into sticky pending bits, retires
// the accepted line and tracks the sticky overflow flag.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   req_i           - request lines
//   offered         - one-hot of the line currently on offer (0 when none)
//   ret             - one-hot of the line accepted this cycle (0 when none)
//   overflow_clr_i  - synchronous clear of overflow_o
//   pending_o       - registered pending bits
//   carried         - pending bits surviving this cycle, excluding new events;
//                     this is the pool the next offer is chosen from
//   overflow_o      - sticky overflow flag
module req_capture
  import pe_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] offered,
  input  logic [N_REQ-1:0] ret,
  input  logic             overflow_clr_i,
  output logic [N_REQ-1:0] pending_o,
  output logic [N_REQ-1:0] carried,
  output logic             overflow_o
);

  logic [N_REQ-1:0] req_q_reg;
  logic [N_REQ-1:0] pending_reg;
  logic [N_REQ-1:0] pending_next;
  logic [N_REQ-1:0] evt;
  logic [N_REQ-1:0] hold;
  logic [N_REQ-1:0] clash;
  logic             overflow_reg;
  logic             overflow_set;
  logic             overflow_next;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_line
    assign evt[gi] = (EDGE_MODE != 0) ? (req_i[gi] & ~req_q_reg[gi]) : req_i[gi];
    // Level mode drops a bit once its request goes away, except the line on
    // offer: an offer is never retracted.
    assign hold[gi]         = (EDGE_MODE != 0) ? 1'b1 : (req_i[gi] | offered[gi]);
    assign carried[gi]      = pending_reg[gi] & ~ret[gi] & hold[gi];
    // A fresh event on the line being retired re-arms it without overflow.
    assign pending_next[gi] = carried[gi] | evt[gi];
    assign clash[gi]        = evt[gi] & pending_reg[gi] & ~ret[gi];
  end

  assign overflow_set  = (EDGE_MODE != 0) && (|clash);
  // Set beats clear when both happen together.
  assign overflow_next = overflow_set | (overflow_reg & ~overflow_clr_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q_reg    <= '0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      req_q_reg    <= req_i;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
    end
  end

  assign pending_o  = pending_reg;
  assign overflow_o = overflow_reg;

endmodule

// File: rtl/irq_pending_arbiter.sv
// Pending-request arbiter: captures request events into sticky pending bits
// and offers the highest-priority eligible line (bit N_REQ-1 highest) on a
// valid/ready handshake, retiring the line when it is accepted.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   req_i           - request lines
//   mask_i          - 1 = line may be offered (masked lines still go pending)
//   overflow_clr_i  - synchronous clear of overflow_o
//   pending_o       - registered pending bits
//   overflow_o      - sticky: new event on a line already pending
//   offer           - idx/valid out, ready in
module irq_pending_arbiter
  import pe_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ-1:0]      mask_i,
  input  logic                  overflow_clr_i,
  output logic [N_REQ-1:0]      pending_o,
  output logic                  overflow_o,
  irq_pending_arbiter_if.master offer
);

  state_e           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             valid_reg, valid_next;
  logic             handshake;
  logic [N_REQ-1:0] offered;
  logic [N_REQ-1:0] ret;
  logic [N_REQ-1:0] carried;
  logic [N_REQ-1:0] elig;

  assign handshake = valid_reg & offer.ready;
  assign offered   = valid_reg ? one_hot(idx_reg) : '0;
  assign ret       = handshake ? offered : '0;

  req_capture #(
    .EDGE_MODE(EDGE_MODE)
  ) u_capture (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .offered        (offered),
    .ret            (ret),
    .overflow_clr_i (overflow_clr_i),
    .pending_o      (pending_o),
    .carried        (carried),
    .overflow_o     (overflow_o)
  );

  // Candidates come from bits that were already pending before this edge
  // (minus the one being retired), so a new request reaches valid two
  // cycles after its edge, while a mask change takes effect in one.
  assign elig = carried & mask_i;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        if (|elig) begin
          idx_next   = highest_set(elig);
          valid_next = 1'b1;
          state_next = OFFER;
        end else begin
          valid_next = 1'b0;
        end
      end
      OFFER: begin
        // Without a handshake the offer is frozen, even if a higher line
        // arrives or the offered line gets masked.
        if (handshake) begin
          if (|elig) begin
            idx_next = highest_set(elig);
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
    end
  end

  assign offer.idx   = idx_reg;
  assign offer.valid = valid_reg;

endmodule
